uart_rx_os: RTL and testbench

Oversampling UART receiver: the receive-side counterpart to the transmitter in `uart_top`, deserialising the serial line into bytes. It recovers 8-bit frames from an asynchronous serial line using a 16x sample tick and checks optional parity and the stop bit. It raises a one-cycle `rx_done` strobe per frame, with the received byte and error flags. It sits between the pad-side `rx_ext` line and the byte-level consumer, with the same frame format and parity controls as the transmit side.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_baud_tick.sv | 21 ++
 rtl/uart_rx_os.sv | 121 ++++++++++++
 tb/tb_uart_rx_os.sv | 130 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, defaults and baud divisor helper.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int UART_OSR = 16;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    function automatic int calc_div(input int clk_freq, input int baud, input int osr);
        return clk_freq / (baud * osr);
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-cycle tick every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    logic [CW-1:0] cnt;
    // Wrap the counter at DIV-1 and strobe tick on the wrap
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
            tick <= cnt == LAST;
        end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver, 8 data bits, optional parity, one stop bit.
// Build option UART_RX_MAJORITY_EN: bit values are a 2-of-3 vote of consecutive tick samples.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int OSR      = UART_OSR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_ext,
    input  logic       par_en,
    input  logic       par_ty,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       parity_error,
    output logic       framing_error,
    output logic       rx_busy
);
    localparam int SW = $clog2(OSR);
    localparam logic [SW-1:0] MID  = SW'(OSR / 2 - 1);
    localparam logic [SW-1:0] LAST = SW'(OSR - 1);
    logic          tick, sync1, sync2, line_q, bit_val, pen_l, pty_l, perr;
    logic [SW-1:0] scnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    state_t        state;

    uart_baud_tick #(.DIV(calc_div(CLK_FREQ, BAUD, OSR))) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Two-flop synchronizer plus one more stage for falling-edge detection
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            line_q <= 1'b1;
        end else begin
            sync1  <= rx_ext;
            sync2  <= sync1;
            line_q <= sync2;
        end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    // Keep the two previous tick samples for the majority vote
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            hist <= 2'b11;
        else if (tick)
            hist <= {hist[0], sync2};
    assign bit_val = (hist[1] & hist[0]) | (hist[1] & sync2) | (hist[0] & sync2);
`else
    assign bit_val = sync2;
`endif

    // Frame FSM: start qualification, data shift, parity check, stop and output update
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state         <= IDLE;
            scnt          <= '0;
            idx           <= '0;
            shreg         <= '0;
            pen_l         <= 1'b0;
            pty_l         <= PAR_EVEN;
            perr          <= 1'b0;
            rx_data       <= '0;
            rx_done       <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                IDLE: if (line_q && !sync2) begin
                    state <= START;
                    scnt  <= '0;
                end
                START: if (tick) begin
                    if (scnt == MID) begin
                        scnt <= '0;
                        if (!bit_val) begin
                            state   <= DATA;
                            rx_busy <= 1'b1;
                            pen_l   <= par_en;
                            pty_l   <= par_ty;
                            idx     <= '0;
                            perr    <= 1'b0;
                        end else
                            state <= IDLE;
                    end else
                        scnt <= scnt + 1'b1;
                end
                default: if (tick) begin
                    scnt <= (scnt == LAST) ? '0 : scnt + 1'b1;
                    if (scnt == LAST) begin
                        if (state == DATA) begin
                            shreg <= {bit_val, shreg[7:1]};
                            idx   <= idx + 1'b1;
                            if (idx == 3'd7)
                                state <= pen_l ? PARITY : STOP;
                        end else if (state == PARITY) begin
                            perr  <= bit_val != (^shreg ^ pty_l);
                            state <= STOP;
                        end else begin
                            rx_data       <= shreg;
                            parity_error  <= pen_l & perr;
                            framing_error <= !bit_val;
                            rx_done       <= 1'b1;
                            rx_busy       <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end
            endcase
        end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed scoreboard bench for uart_rx_os at 50 MHz / 115200 baud.
module tb_uart_rx_os;
    localparam int BIT = 432;
    typedef struct packed {logic [7:0] d; logic pe; logic fe;} res_t;
    logic       clk = 1'b0, rst = 1'b1, rx_ext = 1'b1, par_en = 1'b0, par_ty = 1'b0;
    logic [7:0] rx_data;
    logic       rx_done, parity_error, framing_error, rx_busy;
    res_t       exp_q[$], got_q[$];
    int         checks = 0, errors = 0;

    always #10 clk = ~clk;

    uart_rx_os dut (
        .clk          (clk),
        .rst          (rst),
        .rx_ext       (rx_ext),
        .par_en       (par_en),
        .par_ty       (par_ty),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .rx_busy      (rx_busy)
    );

    // Capture every completed frame as the DUT reports it
    always @(negedge clk)
        if (rx_done)
            got_q.push_back(res_t'({rx_data, parity_error, framing_error}));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx_ext = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic pen, input logic pty, input logic pbit, input logic stop);
        par_en = pen;
        par_ty = pty;
        exp_q.push_back(res_t'({d, pen && (pbit != (^d ^ pty)), !stop}));
        hold(1'b0, BIT);
        check("busy_after_start", {31'd0, rx_busy}, 32'd1);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
        if (pen) hold(pbit, BIT);
        hold(stop, BIT);
    endtask

    task automatic drain(input int n);
        res_t g, e;
        for (int i = 0; i < 4 * BIT && got_q.size() < n; i++) @(negedge clk);
        check("done_count", got_q.size(), n);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check("rx_data", {24'd0, g.d}, {24'd0, e.d});
            check("parity_error", {31'd0, g.pe}, {31'd0, e.pe});
            check("framing_error", {31'd0, g.fe}, {31'd0, e.fe});
        end
        repeat (4) @(negedge clk);
        check("no_extra_done", got_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #5 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_rx_done", {31'd0, rx_done}, 32'd0);
        check("reset_parity_error", {31'd0, parity_error}, 32'd0);
        check("reset_framing_error", {31'd0, framing_error}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b1;
        hold(1'b1, 2 * BIT);
        // good frame with even parity
        send(8'hAF, 1'b1, 1'b0, 1'b0, 1'b1);
        drain(1);
        hold(1'b1, BIT);
        // odd parity requested, wrong parity bit driven
        send(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
        drain(1);
        hold(1'b1, BIT);
        // framing error, then line held low (break)
        send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        drain(1);
        hold(1'b0, 50_000);
        check("break_no_done", got_q.size(), 0);
        hold(1'b1, 2 * BIT);
        check("break_release_no_done", got_q.size(), 0);
        // short low glitch on idle line
        hold(1'b0, 135);
        hold(1'b1, 3 * BIT);
        check("glitch_no_done", got_q.size(), 0);
        check("glitch_busy", {31'd0, rx_busy}, 32'd0);
        check("glitch_rx_data_held", {24'd0, rx_data}, 32'h55);
        check("glitch_framing_held", {31'd0, framing_error}, 32'd1);
        // back-to-back frames with no idle gap
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        drain(2);
        hold(1'b1, BIT);
        // reset in the middle of data bit 4 of 0xFF
        par_en = 1'b0;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(1'b1, BIT);
        hold(1'b1, BIT / 2);
        rst = 1'b0;
        #1;
        check("midreset_rx_data", {24'd0, rx_data}, 32'h00);
        check("midreset_rx_done", {31'd0, rx_done}, 32'd0);
        check("midreset_parity_error", {31'd0, parity_error}, 32'd0);
        check("midreset_framing_error", {31'd0, framing_error}, 32'd0);
        check("midreset_rx_busy", {31'd0, rx_busy}, 32'd0);
        check("midreset_no_done", got_q.size(), 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        hold(1'b1, 2 * BIT);
        check("after_reset_no_done", got_q.size(), 0);
        send(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        drain(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
